periph_apb_initiator: RTL

//  Bus-side APB3 initiator feeding the peripheral-bus slave port: converts a req/gnt/r_valid
//  (TCDM-style) request stream from the SoC interconnect into single APB transfers.

---
 rtl/periph_apb_initiator.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/periph_apb_initiator.sv
// periph_apb_initiator
//   APB3 initiator for the peripheral-bus slave port. It accepts req/gnt/r_valid (TCDM-style)
//   requests from the SoC interconnect and issues each one as a single APB transfer. Only one
//   transfer is outstanding at a time: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//   A write whose byte enables are not all ones is refused without touching the APB bus and
//   answered with an error response.
//
// Optional feature (compile-time macro PERIPH_APB_INIT_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees no PREADY for TIMEOUT_CYCLES cycles is abandoned
//   and answered with an error response. When undefined, ACCESS waits for PREADY forever.
//
// Parameters
//   APB_ADDR_WIDTH  address width of add_i / paddr_o
//   APB_DATA_WIDTH  data width of wdata_i / r_rdata_o / pwdata_o / prdata_i
//   TIMEOUT_CYCLES  ACCESS-phase wait limit (timeout build only), must be >= 1
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_i, gnt_o                 request handshake (gnt_o is combinational, IDLE only)
//   add_i, we_i, be_i, wdata_i   request address, direction, byte enables, write data
//   r_valid_o, r_rdata_o, r_opc_o  one-cycle response pulse, read data, error flag
//   paddr_o, pwdata_o, pwrite_o, psel_o, penable_o   APB request side
//   prdata_i, pready_i, pslverr_i                    APB completion side

module periph_apb_initiator #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // Request side
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0]   add_i,
  input  logic                        we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] be_i,
  input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
  // Response side
  output logic                        r_valid_o,
  output logic [APB_DATA_WIDTH-1:0]   r_rdata_o,
  output logic                        r_opc_o,
  // APB side
  output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
  output logic                        pwrite_o,
  output logic                        psel_o,
  output logic                        penable_o,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q;
  logic [APB_DATA_WIDTH-1:0]   pwdata_q;
  logic                        pwrite_q;
  logic [APB_DATA_WIDTH-1:0]   rdata_q;
  logic                        opc_q;

  logic accept;      // request handshake completes this cycle
  logic bad_be;      // partial write: refused without an APB transfer
  logic complete;    // ACCESS finishes normally this cycle
  logic timeout;     // ACCESS abandoned this cycle

  assign accept   = (state_q == StIdle) && req_i;
  assign bad_be   = we_i && !(&be_i);
  assign complete = (state_q == StAccess) && pready_i;

`ifdef PERIPH_APB_INIT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  // Counts ACCESS cycles already elapsed; held at zero outside ACCESS so it is clear on entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q != StAccess) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th ACCESS cycle; a PREADY in that same cycle still wins.
  assign timeout = (state_q == StAccess) && !pready_i &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  // No wait limit in this build; TIMEOUT_CYCLES has no effect.
  assign timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = bad_be ? StResp : StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (pready_i || timeout) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    gnt_o     = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    r_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_o = req_i;
      end
      StSetup: begin
        psel_o = 1'b1;
      end
      StAccess: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      StResp: begin
        r_valid_o = 1'b1;
      end
      default: begin
        gnt_o = 1'b0;
      end
    endcase
  end

  // Request capture and response data. The response registers hold their value until the
  // next transfer produces a new response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      opc_q    <= 1'b0;
    end else begin
      if (accept) begin
        paddr_q  <= add_i;
        pwdata_q <= wdata_i;
        pwrite_q <= we_i;
        if (bad_be) begin
          rdata_q <= '0;
          opc_q   <= 1'b1;
        end
      end
      if (complete) begin
        rdata_q <= pwrite_q ? '0 : prdata_i;
        opc_q   <= pslverr_i;
      end else if (timeout) begin
        rdata_q <= '0;
        opc_q   <= 1'b1;
      end
    end
  end

  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign r_rdata_o = rdata_q;
  assign r_opc_o   = opc_q;

endmodule
